// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared fetch-side types and constants
package processor_pkg;

  typedef enum logic {
    IF_IDLE = 1'b0,
    IF_RUN  = 1'b1
  } if_state_e;

  localparam int          PC_INCREMENT    = 4;
  localparam logic [31:0] NOP_INSTRUCTION = 32'h00000013;

endpackage

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// rtl/instruction_fetch_unit_fetch_buffer.sv - fetch FIFO with flush and held head output
module fetch_buffer #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_valid,
  output logic             o_full,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_hold;
  logic             w_pop;
  logic             w_push;

  assign o_valid = (r_count != '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign w_pop   = i_pop && o_valid;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_rdata = o_valid ? r_mem[r_rd_ptr] : r_hold;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_hold   <= '0;
    end else begin
      if (o_valid) r_hold <= r_mem[r_rd_ptr];
      if (i_flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC register, fetch FSM and redirect/enqueue arbitration
module instruction_fetch_unit
  import processor_pkg::*;
#(
  parameter int                  WORDSIZE         = 64,
  parameter int                  INSTRUCTION_SIZE = 32,
  parameter logic [WORDSIZE-1:0] RESET_PC         = '0,
  parameter int                  BUFFER_DEPTH     = 2,
  localparam int CW = $clog2(BUFFER_DEPTH) + 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_fetch_en,
  output logic [WORDSIZE-1:0]         o_imem_addr,
  input  logic [INSTRUCTION_SIZE-1:0] i_imem_instruction,
  input  logic                        i_redirect_valid,
  input  logic [WORDSIZE-1:0]         i_redirect_pc,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output logic [INSTRUCTION_SIZE-1:0] o_out_instruction,
  output logic [WORDSIZE-1:0]         o_out_pc,
  output logic [CW-1:0]               o_buffer_count
);

  localparam int EW = WORDSIZE + INSTRUCTION_SIZE;

  if_state_e         r_state;
  logic [WORDSIZE-1:0] r_pc;
  logic              w_full;
  logic              w_deq;
  logic              w_enq;
  logic [EW-1:0]     w_rdata;

  assign o_imem_addr = r_pc;
  assign w_deq       = o_out_valid && i_out_ready;
  // Redirect wins: the instruction returned for the old PC is dropped.
  assign w_enq       = (r_state == IF_RUN) && i_fetch_en && !i_redirect_valid
                       && (!w_full || w_deq);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IF_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      if (i_redirect_valid)
        r_pc <= {i_redirect_pc[WORDSIZE-1:2], 2'b00};
      else if (w_enq)
        r_pc <= r_pc + WORDSIZE'(PC_INCREMENT);
      case (r_state)
        IF_IDLE: if (i_fetch_en)  r_state <= IF_RUN;
        IF_RUN:  if (!i_fetch_en) r_state <= IF_IDLE;
        default: r_state <= IF_IDLE;
      endcase
    end
  end

  fetch_buffer #(
    .WIDTH (EW),
    .DEPTH (BUFFER_DEPTH)
  ) u_fetch_buffer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_redirect_valid),
    .i_push  (w_enq),
    .i_pop   (w_deq),
    .i_wdata ({r_pc, i_imem_instruction}),
    .o_rdata (w_rdata),
    .o_valid (o_out_valid),
    .o_full  (w_full),
    .o_count (o_buffer_count)
  );

  assign o_out_pc          = w_rdata[EW-1:INSTRUCTION_SIZE];
  assign o_out_instruction = w_rdata[INSTRUCTION_SIZE-1:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed and random checks of instruction_fetch_unit against a queue model
module tb_instruction_fetch_unit;

  localparam int          DEPTH   = 2;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_ready;

  logic [63:0] imem_addr;
  logic [31:0] imem_instruction;
  logic        out_valid;
  logic [31:0] out_instruction;
  logic [63:0] out_pc;
  logic [1:0]  buffer_count;

  logic [63:0] w_addr2;
  logic [31:0] w_instr2;
  logic        w_valid2;
  logic [31:0] w_out_instr2;
  logic [63:0] w_out_pc2;
  logic [1:0]  w_count2;

  int n_assert = 0;
  int n_fail   = 0;

  logic [95:0] q[$];
  logic [63:0] m_pc;
  logic        m_run;
  logic [63:0] m_last_pc;
  logic [31:0] m_last_ins;

  function automatic logic [31:0] imem_f(input logic [63:0] a);
    case (a)
      64'd0:   return 32'h00000013;
      64'd4:   return 32'h00100093;
      64'd8:   return 32'h00200113;
      default: return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0000;
    endcase
  endfunction

  assign imem_instruction = imem_f(imem_addr);
  assign w_instr2         = imem_f(w_addr2);

  always #5 clk = ~clk;

  instruction_fetch_unit u_dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_fetch_en         (fetch_en),
    .o_imem_addr        (imem_addr),
    .i_imem_instruction (imem_instruction),
    .i_redirect_valid   (redirect_valid),
    .i_redirect_pc      (redirect_pc),
    .o_out_valid        (out_valid),
    .i_out_ready        (out_ready),
    .o_out_instruction  (out_instruction),
    .o_out_pc           (out_pc),
    .o_buffer_count     (buffer_count)
  );

  instruction_fetch_unit #(.RESET_PC(WRAP_PC)) u_wrap (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_fetch_en         (fetch_en),
    .o_imem_addr        (w_addr2),
    .i_imem_instruction (w_instr2),
    .i_redirect_valid   (1'b0),
    .i_redirect_pc      (64'd0),
    .o_out_valid        (w_valid2),
    .i_out_ready        (1'b1),
    .o_out_instruction  (w_out_instr2),
    .o_out_pc           (w_out_pc2),
    .o_buffer_count     (w_count2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc       = 64'd0;
    m_run      = 1'b0;
    m_last_pc  = 64'd0;
    m_last_ins = 32'd0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Apply inputs for one cycle, compare against the model, then advance both.
  task automatic step(input logic en, input logic rdy, input logic rv, input logic [63:0] rpc);
    int   sz;
    logic pop;
    logic fetch;
    fetch_en = en; out_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    #1;
    sz = q.size();
    if (sz > 0) begin
      m_last_pc  = q[0][95:32];
      m_last_ins = q[0][31:0];
    end
    check("out_valid", 64'(out_valid), 64'(sz > 0));
    check("buffer_count", 64'(buffer_count), 64'(sz));
    check("imem_addr", imem_addr, m_pc);
    check("out_pc", out_pc, m_last_pc);
    check("out_instruction", 64'(out_instruction), 64'(m_last_ins));
    pop = (sz > 0) && rdy;
    if (rv) begin
      q.delete();
      m_pc = {rpc[63:2], 2'b00};
    end else begin
      fetch = m_run && en && (sz < DEPTH || pop);
      if (pop) void'(q.pop_front());
      if (fetch) begin
        q.push_back({m_pc, imem_f(m_pc)});
        m_pc = m_pc + 64'd4;
      end
    end
    m_run = en;
    @(posedge clk); #1;
  endtask

  initial begin
    logic        en, rdy, rv;
    logic [63:0] rpc;
    rst_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 64'd0;
    model_reset();
    @(posedge clk); #1;
    check("rst_imem_addr", imem_addr, 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(buffer_count), 64'd0);
    check("rst_out_pc", out_pc, 64'd0);
    check("rst_out_instr", 64'(out_instruction), 64'd0);
    check("rst_wrap_addr", w_addr2, WRAP_PC);
    rst_n = 1'b1;

    step(1, 1, 0, 0);
    check("seq_addr0", imem_addr, 64'd0);
    check("wrap_addr0", w_addr2, 64'hFFFF_FFFF_FFFF_FFF8);
    step(1, 1, 0, 0);
    check("seq_addr4", imem_addr, 64'd4);
    check("wrap_addr1", w_addr2, 64'hFFFF_FFFF_FFFF_FFFC);
    check("seq_out_ins0", 64'(out_instruction), 64'h00000013);
    step(1, 1, 0, 0);
    check("seq_addr8", imem_addr, 64'd8);
    check("wrap_addr2", w_addr2, 64'd0);
    check("seq_out_pc4", out_pc, 64'd4);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);

    reset_dut();
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    check("stall_count", 64'(buffer_count), 64'd2);
    check("stall_addr", imem_addr, 64'd8);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);

    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    check("pre_redirect_count", 64'(buffer_count), 64'd2);
    step(1, 0, 1, 64'h40);
    check("redir_valid", 64'(out_valid), 64'd0);
    check("redir_count", 64'(buffer_count), 64'd0);
    check("redir_addr", imem_addr, 64'h40);
    step(1, 1, 0, 0);
    check("redir_out_pc", out_pc, 64'h40);
    step(1, 1, 1, 64'h43);
    check("redir_align", imem_addr, 64'h40);

    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    step(0, 0, 1, 64'h1000);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);

    for (int i = 0; i < 400; i++) begin
      en  = ($urandom % 8) != 0;
      rdy = ($urandom % 3) != 0;
      rv  = ($urandom % 16) == 0;
      rpc = (($urandom % 4) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15))
                                  : 64'($urandom_range(0, 255));
      step(en, rdy, rv, rpc);
    end

    reset_dut();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("mid_count", 64'(buffer_count), 64'd1);
    rst_n = 1'b0;
    #2;
    check("async_valid", 64'(out_valid), 64'd0);
    check("async_count", 64'(buffer_count), 64'd0);
    check("async_addr", imem_addr, 64'd0);
    check("async_wrap_addr", w_addr2, WRAP_PC);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
